pc_sequencer: RTL and testbench

//  Controller that sequences the 32-bit program counter register for the fetch stage.
//  - Each cycle it selects the next PC: sequential, branch target, jump target or hold.
//  - Inserts fixed flush bubbles after every control-flow redirect.
//  - Hands the instruction bus to the DMA module through a req/ack handshake,

---
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer for the fetch stage.
//
// Each cycle the next PC is chosen from sequential increment, branch target,
// jump target or hold. Every control-flow redirect is followed by a fixed
// number of flush bubbles, and the instruction bus can be lent to a DMA
// engine via a req/ack handshake while the PC stays frozen.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          pipeline stall; PC holds, no fetch
//   branch_taken   conditional branch resolved taken this cycle
//   branch_target  branch destination (low two bits dropped)
//   jump           unconditional jump this cycle (wins over branch_taken)
//   jump_target    jump destination (low two bits dropped)
//   dma_req        DMA bus request, level, held until the DMA is done
//   dma_ack        bus granted to DMA (registered)
//   pc             current PC (registered)
//   pc_next        value pc loads at the next edge (combinational)
//   fetch_en       instruction memory read enable for pc
//   flush          kill in-flight fetch/decode (registered)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_RUN    | normal fetch; redirect > stall > dma_req > sequential step
// ST_FLUSH  | bubbles after a redirect; pc holds the target, inputs ignored
// ST_DMA    | bus lent to DMA; pc frozen until dma_req falls

module pc_sequencer #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                PC_INC       = 4,
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             dma_req,
  output logic             dma_ack,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             fetch_en,
  output logic             flush
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DMA   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(PC_INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fetch_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      pc_q        <= RESET_VECTOR;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pc_q        <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_d        = pc_q;
    fetch_run   = 1'b0;
    case (state_q)
      ST_RUN: begin
        fetch_run = ~stall;
        if (jump) begin
          pc_d        = jump_target & ALIGN_MASK;
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else if (branch_taken) begin
          pc_d        = branch_target & ALIGN_MASK;
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (dma_req) begin
          state_d = ST_DMA;
        end else begin
          pc_d = pc_q + PC_STEP;
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 4'd1;
        // <= 1 rather than == 1 so a zero count can never strand the FSM here
        if (flush_cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_DMA: begin
        if (!dma_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // dma_ack and flush are pure state decodes, so they come straight off the
  // state register and clear the instant reset is asserted.
  assign dma_ack  = (state_q == ST_DMA);
  assign flush    = (state_q == ST_FLUSH);
  assign fetch_en = fetch_run & ~reset;
  assign pc       = pc_q;
  assign pc_next  = pc_d;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: reset, sequential run, branch and
// flush, jump-vs-branch priority, stall, DMA handshake, wrap-around and
// asynchronous reset in the middle of FLUSH and DMA_HOLD.

module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        dma_req;
  logic        dma_ack;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        fetch_en;
  logic        flush;

  int checks;
  int failures;

  pc_sequencer #(
    .WIDTH(32),
    .RESET_VECTOR(32'h0),
    .PC_INC(4),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .dma_req(dma_req),
    .dma_ack(dma_ack),
    .pc(pc),
    .pc_next(pc_next),
    .fetch_en(fetch_en),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; dma_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", pc, 32'h0); end
    checks++; if (fetch_en !== 1'b0) begin failures++; $display("FAIL reset_fetch_en actual=%b expected=0", fetch_en); end
    step(); step();
    checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL reset_dma_ack actual=%b expected=0", dma_ack); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush actual=%b expected=0", flush); end
    checks++; if (fetch_en !== 1'b0) begin failures++; $display("FAIL reset_fetch_en_clocked actual=%b expected=0", fetch_en); end
    reset = 1'b0;
    #1;
    checks++; if (fetch_en !== 1'b1) begin failures++; $display("FAIL first_fetch_en actual=%b expected=1", fetch_en); end
    checks++; if (pc_next !== 32'h4) begin failures++; $display("FAIL first_pc_next actual=%h expected=%h", pc_next, 32'h4); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = exp_pc + 32'h4;
      checks++; if (pc !== exp_pc || fetch_en !== 1'b1) begin failures++; $display("FAIL seq_pc[%0d] actual=%h/%b expected=%h/1", i, pc, fetch_en, exp_pc); end
    end
  endtask

  task automatic test_branch();
    // pc is 0x10 here
    branch_taken = 1'b1; branch_target = 32'h103;
    #1;
    checks++; if (pc_next !== 32'h100) begin failures++; $display("FAIL branch_pc_next actual=%h expected=%h", pc_next, 32'h100); end
    step();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'h100 || flush !== 1'b1 || fetch_en !== 1'b0) begin failures++; $display("FAIL branch_flush1 pc=%h flush=%b fetch_en=%b expected 100/1/0", pc, flush, fetch_en); end
    // redirect during flush must be ignored
    jump = 1'b1; jump_target = 32'h500;
    #1;
    checks++; if (pc_next !== 32'h100) begin failures++; $display("FAIL flush_ignores_jump actual=%h expected=%h", pc_next, 32'h100); end
    step();
    jump = 1'b0;
    checks++; if (pc !== 32'h100 || flush !== 1'b1 || fetch_en !== 1'b0) begin failures++; $display("FAIL branch_flush2 pc=%h flush=%b fetch_en=%b expected 100/1/0", pc, flush, fetch_en); end
    step();
    checks++; if (pc !== 32'h100 || flush !== 1'b0 || fetch_en !== 1'b1) begin failures++; $display("FAIL branch_target_fetch pc=%h flush=%b fetch_en=%b expected 100/0/1", pc, flush, fetch_en); end
    step();
    checks++; if (pc !== 32'h104) begin failures++; $display("FAIL branch_after actual=%h expected=%h", pc, 32'h104); end
  endtask

  task automatic test_jump_priority();
    jump = 1'b1; jump_target = 32'h200;
    branch_taken = 1'b1; branch_target = 32'h300;
    stall = 1'b1;
    #1;
    checks++; if (pc_next !== 32'h200) begin failures++; $display("FAIL jump_wins_pc_next actual=%h expected=%h", pc_next, 32'h200); end
    step();
    jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    checks++; if (pc !== 32'h200 || flush !== 1'b1) begin failures++; $display("FAIL jump_wins_pc pc=%h flush=%b expected 200/1", pc, flush); end
    step(); step();
    checks++; if (pc !== 32'h200 || fetch_en !== 1'b1 || flush !== 1'b0) begin failures++; $display("FAIL jump_resume pc=%h fetch_en=%b flush=%b expected 200/1/0", pc, fetch_en, flush); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (fetch_en !== 1'b0 || pc_next !== 32'h200) begin failures++; $display("FAIL stall_comb fetch_en=%b pc_next=%h expected 0/200", fetch_en, pc_next); end
    step();
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL stall_hold actual=%h expected=%h", pc, 32'h200); end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h204) begin failures++; $display("FAIL stall_release actual=%h expected=%h", pc, 32'h204); end
  endtask

  task automatic test_dma();
    jump = 1'b1; jump_target = 32'h40;
    step();
    jump = 1'b0;
    step(); step();
    checks++; if (pc !== 32'h40 || fetch_en !== 1'b1) begin failures++; $display("FAIL dma_setup pc=%h fetch_en=%b expected 40/1", pc, fetch_en); end
    dma_req = 1'b1;
    #1;
    checks++; if (dma_ack !== 1'b0 || pc_next !== 32'h40) begin failures++; $display("FAIL dma_req_cycle ack=%b pc_next=%h expected 0/40", dma_ack, pc_next); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (dma_ack !== 1'b1 || pc !== 32'h40 || fetch_en !== 1'b0) begin failures++; $display("FAIL dma_hold[%0d] ack=%b pc=%h fetch_en=%b expected 1/40/0", i, dma_ack, pc, fetch_en); end
    end
    // redirects are ignored while the DMA owns the bus
    jump = 1'b1; jump_target = 32'h700;
    step();
    jump = 1'b0;
    dma_req = 1'b0;
    #1;
    checks++; if (dma_ack !== 1'b1 || pc_next !== 32'h40) begin failures++; $display("FAIL dma_req_drop ack=%b pc_next=%h expected 1/40", dma_ack, pc_next); end
    step();
    checks++; if (dma_ack !== 1'b0 || pc !== 32'h40 || fetch_en !== 1'b1) begin failures++; $display("FAIL dma_release ack=%b pc=%h fetch_en=%b expected 0/40/1", dma_ack, pc, fetch_en); end
    step();
    checks++; if (pc !== 32'h44) begin failures++; $display("FAIL dma_after actual=%h expected=%h", pc, 32'h44); end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    step();
    jump = 1'b0;
    step(); step();
    checks++; if (pc !== 32'hFFFF_FFFC || pc_next !== 32'h0) begin failures++; $display("FAIL wrap_pre pc=%h pc_next=%h expected fffffffc/0", pc, pc_next); end
    step();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap actual=%h expected=%h", pc, 32'h0); end
  endtask

  task automatic test_async_reset();
    // reset while in FLUSH
    branch_taken = 1'b1; branch_target = 32'h80;
    step();
    branch_taken = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (pc !== 32'h0 || flush !== 1'b0 || fetch_en !== 1'b0) begin failures++; $display("FAIL areset_flush pc=%h flush=%b fetch_en=%b expected 0/0/0", pc, flush, fetch_en); end
    step();
    reset = 1'b0;
    step();
    checks++; if (pc !== 32'h4 || flush !== 1'b0) begin failures++; $display("FAIL areset_flush_resume pc=%h flush=%b expected 4/0", pc, flush); end
    // reset while in DMA_HOLD
    dma_req = 1'b1;
    step();
    checks++; if (dma_ack !== 1'b1 || pc !== 32'h4) begin failures++; $display("FAIL areset_dma_setup ack=%b pc=%h expected 1/4", dma_ack, pc); end
    #2 reset = 1'b1;
    #1;
    checks++; if (dma_ack !== 1'b0 || pc !== 32'h0 || fetch_en !== 1'b0) begin failures++; $display("FAIL areset_dma ack=%b pc=%h fetch_en=%b expected 0/0/0", dma_ack, pc, fetch_en); end
    dma_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++; if (pc !== 32'h4 || dma_ack !== 1'b0) begin failures++; $display("FAIL areset_dma_resume pc=%h ack=%b expected 4/0", pc, dma_ack); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_stall();
    test_dma();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
